sid_table_sched: RTL

SID_TABLE_SCHED -- requirements
Module: sid_table_sched

---
 rtl/sid_table_sched.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sid_table_sched.sv
// Sequencer that time-shares one combined-waveform table among NVOICE voices.
// Each 1 MHz strobe snapshots all voice indices and sweeps them through the table in order.
module sid_table_sched #(
  parameter int unsigned NVOICE  = 3,
  parameter int unsigned ROM_LAT = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce_1m,
  input  logic [12*NVOICE-1:0]   acc_ps,
  input  logic [12*NVOICE-1:0]   acc_t,
  output logic [11:0]            tbl_acc_ps,
  output logic [11:0]            tbl_acc_t,
  input  logic [7:0]             tbl_st,
  input  logic [7:0]             tbl_pt,
  input  logic [7:0]             tbl_ps,
  input  logic [7:0]             tbl_pst,
  output logic [32*NVOICE-1:0]   wave_out,
  output logic [NVOICE-1:0]      wave_upd,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun,
  input  logic                   overrun_clr
);

  localparam int unsigned VW       = (NVOICE > 1) ? $clog2(NVOICE) : 1;
  localparam logic [VW-1:0] VLast  = VW'(NVOICE - 1);
  // WAIT covers ROM_LAT-1 cycles, counted down to zero
  localparam logic [2:0] WaitInit  = (ROM_LAT > 1) ? 3'(ROM_LAT - 2) : 3'd0;

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StStore, StFin} state_e;

  state_e        state_q, state_d;
  logic [VW-1:0] v_q, v_d;
  logic [2:0]    wcnt_q, wcnt_d;
  logic          addr_ld;
  logic          store;

  logic [11:0]       shadow_ps_q [NVOICE];
  logic [11:0]       shadow_t_q  [NVOICE];
  logic [11:0]       addr_ps_q;
  logic [11:0]       addr_t_q;
  logic [31:0]       wave_q      [NVOICE];
  logic [NVOICE-1:0] upd_q;
  logic              overrun_q;

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    wcnt_d  = wcnt_q;
    addr_ld = 1'b0;
    store   = 1'b0;
    unique case (state_q)
      StIdle: ;
      StIssue: begin
        addr_ld = 1'b1;
        if (ROM_LAT == 1) begin
          state_d = StStore;
        end else begin
          state_d = StWait;
          wcnt_d  = WaitInit;
        end
      end
      StWait: begin
        if (wcnt_q == 3'd0) state_d = StStore;
        else                wcnt_d  = wcnt_q - 3'd1;
      end
      StStore: begin
        store = 1'b1;
        if (v_q == VLast) begin
          state_d = StFin;
        end else begin
          v_d     = v_q + 1'b1;
          state_d = StIssue;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // A strobe restarts the sweep from any state; the current edge's store/load still happens
    if (ce_1m) begin
      state_d = StIssue;
      v_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      v_q     <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NVOICE; i++) begin
        shadow_ps_q[i] <= '0;
        shadow_t_q[i]  <= '0;
      end
    end else if (ce_1m) begin
      for (int i = 0; i < NVOICE; i++) begin
        shadow_ps_q[i] <= acc_ps[12*i +: 12];
        shadow_t_q[i]  <= acc_t[12*i +: 12];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_ps_q <= '0;
      addr_t_q  <= '0;
      upd_q     <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NVOICE; i++) begin
        wave_q[i] <= '0;
      end
    end else begin
      upd_q <= '0;
      if (addr_ld) begin
        addr_ps_q <= shadow_ps_q[v_q];
        addr_t_q  <= shadow_t_q[v_q];
      end
      if (store) begin
        wave_q[v_q] <= {tbl_pst, tbl_ps, tbl_pt, tbl_st};
        upd_q[v_q]  <= 1'b1;
      end
      // Set has priority over a coincident clear
      if (ce_1m && busy) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NVOICE; i++) begin : g_wave
    assign wave_out[32*i +: 32] = wave_q[i];
  end

  assign tbl_acc_ps = addr_ps_q;
  assign tbl_acc_t  = addr_t_q;
  assign wave_upd   = upd_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StFin);

endmodule
